// File: rtl/cam_pkg.sv
// Shared constants for the camera frame-capture slice: FSM state codes,
// default image dimensions and pixel-count helper.
package cam_pkg;

    localparam int unsigned DEF_IMG_W = 320;
    localparam int unsigned DEF_IMG_H = 240;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned STATE_W   = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_SKIP    = 2'd1;
    localparam logic [STATE_W-1:0] ST_SYNC    = 2'd2;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 2'd3;

    function automatic int unsigned pix_count(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    localparam int unsigned DEF_PIX_COUNT = pix_count(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/rgb565_byte_packer.sv
// Pairs camera bytes (high byte first) into RGB565 pixels and raises a
// one-cycle write strobe the cycle after each second byte.
module rgb565_byte_packer (
    input  logic        pclk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        sample_i,
    input  logic        wr_allow_i,
    input  logic [7:0]  data_i,
    output logic        phase_o,
    output logic        we_o,
    output logic [15:0] pix_o
);

    logic        phase_q, phase_d;
    logic        we_q, we_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] pix_q, pix_d;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        pix_d   = pix_q;
        we_d    = 1'b0;
        if (clear_i) begin
            phase_d = 1'b0;
        end else if (sample_i) begin
            if (!phase_q) begin
                hi_d    = data_i;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                // Out-of-window pixels still advance the phase but never write.
                if (wr_allow_i) begin
                    we_d  = 1'b1;
                    pix_d = {hi_q, data_i};
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            phase_q <= 1'b0;
            we_q    <= 1'b0;
            hi_q    <= 8'd0;
            pix_q   <= 16'd0;
        end else begin
            phase_q <= phase_d;
            we_q    <= we_d;
            hi_q    <= hi_d;
            pix_q   <= pix_d;
        end
    end

    assign phase_o = phase_q;
    assign we_o    = we_q;
    assign pix_o   = pix_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Camera frame capture: skips settling frames, writes RGB565 pixels into a
// ping-pong frame buffer and hands completed banks to the display reader.
module frame_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W       = DEF_IMG_W,
    parameter int unsigned IMG_H       = DEF_IMG_H,
    parameter int unsigned SKIP_FRAMES = 2
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              cfg_done,
    input  logic              cap_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              wbank,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(pix_count(IMG_W, IMG_H) - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   skip_q, skip_d;
    logic [CNT_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               err_q, err_d;
    logic               wbank_q, wbank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
    logic               vsync_q, href_q;

    logic vsync_rise, vsync_fall, href_fall;
    logic pk_clear, pk_sample, pk_phase, pk_we, in_bounds, pix_done;
    logic [15:0] pk_pix;

    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign href_fall  = ~href & href_q;
    assign pk_sample  = (state_q == ST_CAPTURE) & href;
    assign pix_done   = pk_sample & pk_phase;
    assign in_bounds  = (col_q < CNT_W'(IMG_W)) && (row_q < CNT_W'(IMG_H));

    rgb565_byte_packer u_packer (
        .pclk       (pclk),
        .reset      (reset),
        .clear_i    (pk_clear),
        .sample_i   (pk_sample),
        .wr_allow_i (in_bounds),
        .data_i     (data),
        .phase_o    (pk_phase),
        .we_o       (pk_we),
        .pix_o      (pk_pix)
    );

    // Next-state, counter and bank logic.
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        err_d     = err_q;
        wbank_d   = wbank_q;
        rd_bank_d = rd_bank_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        pk_clear  = 1'b0;

        if (pk_we && (addr_q != PIX_LAST)) addr_d = addr_q + ADDR_W'(1);
        if (pix_done && (col_q != '1))     col_d  = col_q + CNT_W'(1);

        if (!cfg_done) begin
            state_d  = ST_IDLE;
            pk_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cap_en) begin
                        skip_d  = '0;
                        state_d = (SKIP_FRAMES == 0) ? ST_SYNC : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (SKIP_FRAMES == 0) begin
                        state_d = ST_SYNC;
                    end else if (vsync_rise) begin
                        skip_d = skip_q + CNT_W'(1);
                        if (skip_q + CNT_W'(1) >= CNT_W'(SKIP_FRAMES)) state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (vsync_fall) begin
                        state_d  = ST_CAPTURE;
                        col_d    = '0;
                        row_d    = '0;
                        addr_d   = '0;
                        err_d    = 1'b0;
                        pk_clear = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (vsync_rise) begin
                        if ((row_q == CNT_W'(IMG_H)) && !err_q) begin
                            rd_bank_d = wbank_q;
                            wbank_d   = ~wbank_q;
                            done_d    = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = cap_en ? ST_SYNC : ST_IDLE;
                    end else if (href_fall) begin
                        // A line must carry exactly IMG_W whole pixels.
                        if ((col_q != CNT_W'(IMG_W)) || pk_phase) err_d = 1'b1;
                        if (row_q != '1) row_d = row_q + CNT_W'(1);
                        col_d    = '0;
                        pk_clear = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            skip_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            wbank_q   <= 1'b0;
            rd_bank_q <= 1'b1;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            wbank_q   <= wbank_d;
            rd_bank_q <= rd_bank_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            vsync_q   <= vsync;
            href_q    <= href;
        end
    end

    assign we         = pk_we;
    assign wAddr      = addr_q;
    assign wData      = pk_pix;
    assign wbank      = wbank_q;
    assign rd_bank    = rd_bank_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl: random pixel bytes and line gaps, expected
// write list and frame outcome derived from frame geometry.
`timescale 1ns/1ps
module tb_frame_capture_ctrl;
    import cam_pkg::*;

    localparam int unsigned W    = 16;
    localparam int unsigned H    = 8;
    localparam int unsigned SKIP = 2;
    localparam int unsigned PIX  = W * H;

    typedef struct packed {
        logic [31:0] cyc;
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        pclk, reset, cfg_done, cap_en, vsync, href;
    logic [7:0]  data;
    logic        we, wbank, rd_bank, frame_done, frame_err;
    logic [16:0] wAddr;
    logic [15:0] wData;

    frame_capture_ctrl #(.IMG_W(W), .IMG_H(H), .SKIP_FRAMES(SKIP)) dut (
        .pclk       (pclk),
        .reset      (reset),
        .cfg_done   (cfg_done),
        .cap_en     (cap_en),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .wbank      (wbank),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          dbl_we   = 0;
    logic        we_prev  = 1'b0;
    wr_t         mon_w;
    wr_t         act_q[$];
    wr_t         exp_q[$];
    logic [7:0]  preset_q[$];
    int          exp_n, act0, done0, err0;
    logic        mwb, mrd;
    logic [16:0] waddr_vs;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Write and pulse monitor, sampled mid-cycle.
    always @(negedge pclk) begin
        if (we === 1'b1) begin
            mon_w.cyc  = cyc;
            mon_w.addr = wAddr;
            mon_w.data = wData;
            act_q.push_back(mon_w);
        end
        if (we === 1'b1 && we_prev === 1'b1) dbl_we <= dbl_we + 1;
        we_prev <= we;
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (frame_err === 1'b1)  err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] next_byte();
        logic [7:0] b;
        if (preset_q.size() > 0) b = preset_q.pop_front();
        else b = 8'($urandom);
        return b;
    endfunction

    task automatic begin_frame();
        exp_q.delete();
        exp_n = 0;
        act0  = act_q.size();
        done0 = done_cnt;
        err0  = err_cnt;
    endtask

    task automatic send_lines(input int row0, input int nl, input int npix,
                              input int short_row, input bit cap);
        for (int r = row0; r < row0 + nl; r++) begin
            int np;
            np = (r == short_row) ? npix - 1 : npix;
            for (int c = 0; c < np; c++) begin
                logic [7:0] hi, lo;
                wr_t e;
                hi = next_byte();
                lo = next_byte();
                @(negedge pclk); href = 1'b1; data = hi;
                @(negedge pclk); data = lo;
                if (cap && r < int'(H) && c < int'(W)) begin
                    e.cyc  = cyc + 1;
                    e.addr = 17'(exp_n);
                    e.data = {hi, lo};
                    exp_q.push_back(e);
                    exp_n++;
                end
            end
            @(negedge pclk); href = 1'b0; data = 8'($urandom);
            repeat ($urandom_range(1, 4)) @(negedge pclk);
        end
    endtask

    task automatic send_vsync();
        @(negedge pclk); vsync = 1'b1;
        @(negedge pclk);
        @(negedge pclk); waddr_vs = wAddr;
        @(negedge pclk); vsync = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    // pulse: 0 = no outcome, 1 = frame_done expected, 2 = frame_err expected
    task automatic check_frame(input string tag, input int pulse);
        int na, f0;
        wr_t a, e;
        na = act_q.size() - act0;
        chk({tag, "_wcount"}, 96'(na), 96'(exp_q.size()));
        f0 = n_fail;
        for (int i = 0; i < exp_q.size() && i < na; i++) begin
            a = act_q[act0 + i];
            e = exp_q[i];
            chk({tag, "_write"}, 96'(a), 96'(e));
            if (n_fail > f0) break;
        end
        chk({tag, "_done"}, 96'(done_cnt - done0), 96'(pulse == 1));
        chk({tag, "_err"},  96'(err_cnt - err0),   96'(pulse == 2));
        if (pulse == 1) begin
            mrd = mwb;
            mwb = ~mwb;
        end
        if (pulse != 0)
            chk({tag, "_waddr"}, 96'(waddr_vs), 96'((exp_n > int'(PIX) - 1) ? int'(PIX) - 1 : exp_n));
        chk({tag, "_wbank"},   96'(wbank),   96'(mwb));
        chk({tag, "_rd_bank"}, 96'(rd_bank), 96'(mrd));
    endtask

    task automatic frame(input string tag, input int nl, input int npix,
                         input int short_row, input bit cap, input int pulse);
        begin_frame();
        send_lines(0, nl, npix, short_row, cap);
        send_vsync();
        check_frame(tag, pulse);
    endtask

    initial begin
        reset = 1'b1; cfg_done = 1'b0; cap_en = 1'b0;
        vsync = 1'b0; href = 1'b0; data = 8'd0;
        mwb = 1'b0; mrd = 1'b1; waddr_vs = '0;

        // Reset state
        repeat (3) @(negedge pclk);
        chk("rst_we",      96'(we),         96'(0));
        chk("rst_waddr",   96'(wAddr),      96'(0));
        chk("rst_wdata",   96'(wData),      96'(0));
        chk("rst_wbank",   96'(wbank),      96'(0));
        chk("rst_rd_bank", 96'(rd_bank),    96'(1));
        chk("rst_done",    96'(frame_done), 96'(0));
        chk("rst_err",     96'(frame_err),  96'(0));
        chk("rst_state",   96'(dut.state_q), 96'(ST_IDLE));
        reset = 1'b0;
        @(negedge pclk); cfg_done = 1'b1; cap_en = 1'b1;
        repeat (2) @(negedge pclk);

        // Power-up skip, then first good frame
        frame("skip1", H, W, -1, 1'b0, 0);
        frame("skip2", H, W, -1, 1'b0, 0);
        frame("cap3",  H, W, -1, 1'b1, 1);

        // Byte order of the first two pixels
        preset_q.push_back(8'hF8); preset_q.push_back(8'h00);
        preset_q.push_back(8'h07); preset_q.push_back(8'hE0);
        frame("byteorder", H, W, -1, 1'b1, 1);
        chk("bo_count_ge2", 96'(act_q.size() - act0 >= 2), 96'(1));
        if (act_q.size() - act0 >= 2) begin
            chk("bo_pix0", 96'({act_q[act0].addr, act_q[act0].data}),         96'({17'd0, 16'hF800}));
            chk("bo_pix1", 96'({act_q[act0 + 1].addr, act_q[act0 + 1].data}), 96'({17'd1, 16'h07E0}));
        end

        // Short line drops the frame; the next one commits
        frame("short", H, W, 3, 1'b1, 2);
        frame("after_short", H, W, -1, 1'b1, 1);

        // Overlong lines and an extra row
        frame("overlong", H + 1, W + 10, -1, 1'b1, 2);

        // cap_en drop mid-frame
        begin_frame();
        send_lines(0, H / 2, W, -1, 1'b1);
        cap_en = 1'b0;
        send_lines(H / 2, H - H / 2, W, -1, 1'b1);
        send_vsync();
        check_frame("capdrop", 1);
        repeat (2) @(negedge pclk);
        chk("capdrop_idle", 96'(dut.state_q), 96'(ST_IDLE));
        frame("idle_frame", H, W, -1, 1'b0, 0);

        // Reset mid-frame
        cap_en = 1'b1;
        frame("rskip1", H, W, -1, 1'b0, 0);
        frame("rskip2", H, W, -1, 1'b0, 0);
        send_lines(0, 3, W, -1, 1'b1);
        @(negedge pclk); reset = 1'b1;
        @(negedge pclk);
        chk("midrst_we",      96'(we),          96'(0));
        chk("midrst_waddr",   96'(wAddr),       96'(0));
        chk("midrst_wbank",   96'(wbank),       96'(0));
        chk("midrst_rd_bank", 96'(rd_bank),     96'(1));
        chk("midrst_state",   96'(dut.state_q), 96'(ST_IDLE));
        reset = 1'b0;
        mwb = 1'b0; mrd = 1'b1;
        @(negedge pclk);

        // cfg_done loss mid-frame discards silently
        frame("cskip1", H, W, -1, 1'b0, 0);
        frame("cskip2", H, W, -1, 1'b0, 0);
        begin_frame();
        send_lines(0, 3, W, -1, 1'b1);
        cfg_done = 1'b0;
        repeat (2) @(negedge pclk);
        chk("cfgdrop_idle", 96'(dut.state_q), 96'(ST_IDLE));
        send_lines(3, H - 3, W, -1, 1'b0);
        send_vsync();
        check_frame("cfgdrop", 0);

        chk("we_back_to_back", 96'(dbl_we), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
